// File: rtl/im_loader.sv
// im_loader: byte-stream writer that fills the 128-byte instruction memory
// Ports: clk/rstn (async active-low reset); start, base_addr, load_words request a load;
//   in_valid/in_data/in_ready host byte stream; wr_en/wr_addr/wr_data IM byte-write port;
//   cpu_hold stalls fetch, busy marks a load, done pulses at completion, err flags a bad checksum.
// Build option: define IM_LOADER_CHKSUM_EN to consume and check a trailing XOR checksum byte.
module im_loader #(
  parameter int ADDR_W    = 7,
  parameter int CNT_W     = 8,
  parameter int WORDS_MAX = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [5:0]        load_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);
  if (2**CNT_W < 4*WORDS_MAX) begin : g_cnt_chk
    $error("im_loader: CNT_W too narrow for WORDS_MAX");
  end
  typedef enum logic [1:0] {IDLE, LOAD, CHK, DONE} state_t;
`ifdef IM_LOADER_CHKSUM_EN
  localparam state_t TAIL = CHK;
`else
  localparam state_t TAIL = DONE;
`endif
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, tgt_q, tgt_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d, in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;
  logic              acc;
`ifdef IM_LOADER_CHKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              err_q, err_d;
`endif
  assign acc = in_valid && in_ready_q;
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef IM_LOADER_CHKSUM_EN
    sum_d     = sum_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        ptr_d   = base_addr & ~ADDR_W'(3);
        tgt_d   = CNT_W'({load_words, 2'b00});
        cnt_d   = '0;
        state_d = (load_words == 6'd0) ? TAIL : LOAD;
`ifdef IM_LOADER_CHKSUM_EN
        sum_d   = 8'h00;
        err_d   = 1'b0;
`endif
      end
      LOAD: if (acc) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = in_data;
        ptr_d     = ptr_q + ADDR_W'(1);
        cnt_d     = cnt_q + CNT_W'(1);
        state_d   = (cnt_q + CNT_W'(1) == tgt_q) ? TAIL : LOAD;
`ifdef IM_LOADER_CHKSUM_EN
        sum_d     = sum_q ^ in_data;
`endif
      end
`ifdef IM_LOADER_CHKSUM_EN
      CHK: if (acc) begin
        err_d   = in_data != sum_q;
        state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    in_ready_d = (state_d == LOAD) || (state_d == CHK);
    busy_d     = state_d != IDLE;
    done_d     = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      tgt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef IM_LOADER_CHKSUM_EN
      sum_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef IM_LOADER_CHKSUM_EN
      sum_q      <= sum_d;
      err_q      <= err_d;
`endif
    end
  end
  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign cpu_hold = busy_q;
  assign done     = done_q;
`ifdef IM_LOADER_CHKSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif
endmodule
